// File: rtl/sass_seq_ctrl.sv
// Eight-step sequencer controller for the SaSS synth: live key pass-through, step capture, playback.
// Optional staccato gating in PLAY is enabled by defining SASS_SEQ_GATE_EN.
module sass_seq_ctrl #(
  parameter int unsigned TICK_SLOW = 5_000_000,
  parameter int unsigned TICK_MED  = 2_500_000,
  parameter int unsigned TICK_FAST = 1_250_000,
  parameter int unsigned CNT_W     = 23
) (
  input  logic        clk,
  input  logic        n_rst,
  input  logic [14:0] piano_keys,
  input  logic        seq_power,
  input  logic        tempo_select,
  input  logic        seq_play,
  output logic [14:0] note_out,
  output logic [1:0]  mode_out,
  output logic [7:0]  beat_led,
  output logic        seq_led_on
);

  typedef enum logic [1:0] {
    StOff  = 2'b00,
    StEdit = 2'b01,
    StPlay = 2'b10
  } state_e;

  localparam logic [CNT_W-1:0] LastSlow = CNT_W'(TICK_SLOW - 1);
  localparam logic [CNT_W-1:0] LastMed  = CNT_W'(TICK_MED - 1);
  localparam logic [CNT_W-1:0] LastFast = CNT_W'(TICK_FAST - 1);

  state_e           state_q;
  logic [14:0]      keys_q;
  logic             power_q;
  logic             tempo_in_q;
  logic             play_q;
  logic [14:0]      step_q [8];
  logic [2:0]       ptr_q;
  logic [1:0]       tempo_q;
  logic [CNT_W-1:0] cnt_q;

  logic             key_rise;
  logic             power_rise;
  logic             tempo_rise;
  logic             play_rise;
  logic [CNT_W-1:0] cnt_last;
  logic [14:0]      play_note;

  assign key_rise   = |(piano_keys & ~keys_q);
  assign power_rise = seq_power & ~power_q;
  assign tempo_rise = tempo_select & ~tempo_in_q;
  assign play_rise  = seq_play & ~play_q;

  always_comb begin
    cnt_last = LastSlow;
    unique case (tempo_q)
      2'd1:    cnt_last = LastMed;
      2'd2:    cnt_last = LastFast;
      default: cnt_last = LastSlow;
    endcase
  end

  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      state_q    <= StOff;
      keys_q     <= '0;
      power_q    <= 1'b0;
      tempo_in_q <= 1'b0;
      play_q     <= 1'b0;
      ptr_q      <= '0;
      tempo_q    <= '0;
      cnt_q      <= '0;
      for (int i = 0; i < 8; i++) step_q[i] <= '0;
    end else begin
      keys_q     <= piano_keys;
      power_q    <= seq_power;
      tempo_in_q <= tempo_select;
      play_q     <= seq_play;

      // Tempo cycles 0 -> 1 -> 2 -> 0 regardless of state.
      if (tempo_rise) tempo_q <= (tempo_q == 2'd2) ? 2'd0 : tempo_q + 2'd1;

      case (state_q)
        StOff: begin
          if (power_rise) begin
            state_q <= StEdit;
            ptr_q   <= '0;
            for (int i = 0; i < 8; i++) step_q[i] <= '0;
          end
        end
        StEdit: begin
          if (power_rise) begin
            state_q <= StOff;
          end else if (play_rise) begin
            state_q <= StPlay;
            ptr_q   <= '0;
            cnt_q   <= '0;
          end else if (key_rise) begin
            // Whole vector is stored so chords survive capture.
            step_q[ptr_q] <= piano_keys;
            ptr_q         <= ptr_q + 3'd1;
          end
        end
        StPlay: begin
          if (power_rise) begin
            state_q <= StOff;
            cnt_q   <= '0;
          end else if (play_rise) begin
            state_q <= StEdit;
            ptr_q   <= '0;
            cnt_q   <= '0;
          end else if (tempo_rise) begin
            cnt_q <= '0;
          end else if (cnt_q == cnt_last) begin
            cnt_q <= '0;
            ptr_q <= ptr_q + 3'd1;
          end else begin
            cnt_q <= cnt_q + 1'b1;
          end
        end
        default: state_q <= StOff;
      endcase
    end
  end

`ifdef SASS_SEQ_GATE_EN
  localparam logic [CNT_W-1:0] GateSlow = CNT_W'(TICK_SLOW - TICK_SLOW / 4);
  localparam logic [CNT_W-1:0] GateMed  = CNT_W'(TICK_MED - TICK_MED / 4);
  localparam logic [CNT_W-1:0] GateFast = CNT_W'(TICK_FAST - TICK_FAST / 4);

  logic [CNT_W-1:0] gate_thr;

  always_comb begin
    gate_thr = GateSlow;
    unique case (tempo_q)
      2'd1:    gate_thr = GateMed;
      2'd2:    gate_thr = GateFast;
      default: gate_thr = GateSlow;
    endcase
    play_note = (cnt_q >= gate_thr) ? '0 : step_q[ptr_q];
  end
`else
  assign play_note = step_q[ptr_q];
`endif

  // keys_q is the one-cycle registered copy, giving the live path its single-clock latency.
  assign note_out   = (state_q == StPlay) ? play_note : keys_q;
  assign mode_out   = state_q;
  assign beat_led   = (state_q == StOff) ? 8'h00 : (8'h01 << ptr_q);
  assign seq_led_on = (state_q != StOff);

endmodule

// File: tb/tb_sass_seq_ctrl.sv
// Scoreboard bench for sass_seq_ctrl: directed test-plan sequences followed by random buttons/keys.
module tb_sass_seq_ctrl;

  localparam int unsigned TS = 8;
  localparam int unsigned TM = 4;
  localparam int unsigned TF = 2;

  logic        clk = 1'b0;
  logic        n_rst = 1'b0;
  logic [14:0] piano_keys = '0;
  logic        seq_power = 1'b0;
  logic        tempo_select = 1'b0;
  logic        seq_play = 1'b0;
  logic [14:0] note_out;
  logic [1:0]  mode_out;
  logic [7:0]  beat_led;
  logic        seq_led_on;

  sass_seq_ctrl #(
    .TICK_SLOW(TS),
    .TICK_MED (TM),
    .TICK_FAST(TF),
    .CNT_W    (4)
  ) dut (
    .clk         (clk),
    .n_rst       (n_rst),
    .piano_keys  (piano_keys),
    .seq_power   (seq_power),
    .tempo_select(tempo_select),
    .seq_play    (seq_play),
    .note_out    (note_out),
    .mode_out    (mode_out),
    .beat_led    (beat_led),
    .seq_led_on  (seq_led_on)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [14:0] note;
    logic [1:0]  mode;
    logic [7:0]  beat;
    logic        led;
  } exp_t;

  exp_t exp_q[$];
  int   n_tests = 0;
  int   n_fail  = 0;

  // Reference model: mode 0 OFF, 1 EDIT, 2 PLAY.
  int          m_mode;
  int          m_ptr;
  int          m_tempo;
  int          m_cnt;
  logic [14:0] m_mem [8];
  logic [14:0] m_keys;
  logic        m_pwr;
  logic        m_tmp;
  logic        m_ply;

  function automatic int period(input int tempo);
    return (tempo == 0) ? TS : (tempo == 1) ? TM : TF;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    n_tests++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: got %h, required %h at %0t", name, act, req, $time);
    end
  endtask

  task automatic push_exp();
    exp_t e;
    int per;
    per    = period(m_tempo);
    e.mode = 2'(m_mode);
    e.led  = (m_mode != 0);
    e.beat = (m_mode == 0) ? 8'h00 : 8'(1 << m_ptr);
    if (m_mode == 2) begin
      e.note = m_mem[m_ptr];
`ifdef SASS_SEQ_GATE_EN
      if (m_cnt >= per - per / 4) e.note = '0;
`endif
    end else begin
      e.note = m_keys;
    end
    exp_q.push_back(e);
  endtask

  task automatic model_reset();
    m_mode = 0; m_ptr = 0; m_tempo = 0; m_cnt = 0;
    m_keys = '0; m_pwr = 0; m_tmp = 0; m_ply = 0;
    for (int i = 0; i < 8; i++) m_mem[i] = '0;
  endtask

  task automatic model_step(input logic [14:0] k, input logic p, input logic t, input logic s);
    bit kr, pr, tr, sr;
    kr = ((k & ~m_keys) != 0);
    pr = p && !m_pwr;
    tr = t && !m_tmp;
    sr = s && !m_ply;
    m_keys = k; m_pwr = p; m_tmp = t; m_ply = s;
    if (tr) m_tempo = (m_tempo + 1) % 3;
    if (m_mode == 0) begin
      if (pr) begin
        m_mode = 1; m_ptr = 0;
        for (int i = 0; i < 8; i++) m_mem[i] = '0;
      end
    end else if (m_mode == 1) begin
      if (pr) m_mode = 0;
      else if (sr) begin m_mode = 2; m_ptr = 0; m_cnt = 0; end
      else if (kr) begin m_mem[m_ptr] = k; m_ptr = (m_ptr + 1) % 8; end
    end else begin
      if (pr) m_mode = 0;
      else if (sr) begin m_mode = 1; m_ptr = 0; end
      else if (tr) m_cnt = 0;
      else begin
        m_cnt++;
        if (m_cnt == period(m_tempo)) begin m_cnt = 0; m_ptr = (m_ptr + 1) % 8; end
      end
    end
    push_exp();
  endtask

  task automatic drive(input logic [14:0] k, input logic p, input logic t, input logic s);
    @(negedge clk);
    piano_keys = k; seq_power = p; tempo_select = t; seq_play = s;
    model_step(k, p, t, s);
  endtask

  task automatic do_reset();
    @(negedge clk);
    n_rst = 1'b0;
    piano_keys = '0; seq_power = 0; tempo_select = 0; seq_play = 0;
    model_reset();
    push_exp();
    #1;
    chk("async_rst_mode", 32'(mode_out), 32'd0);
    chk("async_rst_beat", 32'(beat_led), 32'd0);
    chk("async_rst_note", 32'(note_out), 32'd0);
    @(negedge clk);
    n_rst = 1'b1;
    model_step('0, 0, 0, 0);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) drive(piano_keys, 0, 0, 0);
  endtask

  initial begin : monitor
    exp_t e;
    forever begin
      @(posedge clk);
      #1;
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        chk("note_out", 32'(note_out), 32'(e.note));
        chk("mode_out", 32'(mode_out), 32'(e.mode));
        chk("beat_led", 32'(beat_led), 32'(e.beat));
        chk("seq_led_on", 32'(seq_led_on), 32'(e.led));
      end
    end
  end

  initial begin : watchdog
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached, required normal completion");
    $fatal(1, "timeout");
  end

  initial begin : stim
    logic [14:0] k;
    model_reset();
    do_reset();
    idle(3);
    drive(15'h0005, 0, 0, 0);
    idle(2);
    drive('0, 0, 0, 0);
    // Enter EDIT and capture one key per step, wrapping the pointer.
    drive('0, 1, 0, 0);
    drive('0, 0, 0, 0);
    for (int i = 0; i < 9; i++) begin
      drive(15'(1 << (i % 8)), 0, 0, 0);
      drive('0, 0, 0, 0);
    end
    drive('0, 0, 0, 1);
    drive('0, 0, 0, 0);
    idle(70);
    drive('0, 0, 1, 0);
    drive('0, 0, 0, 0);
    idle(20);
    drive('0, 0, 1, 0);
    drive('0, 0, 0, 0);
    idle(5);
    drive('0, 0, 1, 0);
    drive('0, 0, 0, 0);
    idle(20);
    // Back to EDIT, then power+play together must go OFF.
    drive('0, 0, 0, 1);
    drive('0, 0, 0, 0);
    drive('0, 1, 0, 1);
    drive('0, 0, 0, 0);
    drive('0, 1, 0, 0);
    drive('0, 0, 0, 0);
    drive(15'h0010, 0, 0, 0);
    drive('0, 0, 0, 0);
    drive(15'h0003, 0, 0, 1);
    drive('0, 0, 0, 0);
    idle(13);
    do_reset();
    idle(4);
    for (int i = 0; i < 2000; i++) begin
      if ($urandom_range(0, 499) == 0) begin
        do_reset();
      end else begin
        k = piano_keys;
        case ($urandom_range(0, 5))
          0: k = 15'($urandom);
          1: k = '0;
          default: ;
        endcase
        drive(k, $urandom_range(0, 29) == 0, $urandom_range(0, 14) == 0,
              $urandom_range(0, 19) == 0);
      end
    end
    idle(2);
    @(negedge clk);
    @(negedge clk);
    chk("queue_drained", 32'(exp_q.size()), 32'd0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/sass_seq_ctrl.md
# sass_seq_ctrl

Eight-step sequencer controller for the SaSS synth. It sits between the debounced, synchronized front-panel inputs (piano keys, sequencer power, tempo, play) and the oscillator/PWM datapath. It decides which 15-bit key vector drives the oscillator each cycle:
- live keys when the sequencer is off or being edited;
- stored steps, advanced at a selectable tempo, when playing.

It also drives the mode, beat and sequencer LEDs.

## Interface
Parameters:
- TICK_SLOW, default 5_000_000: clock cycles per step at tempo 0.
- TICK_MED, default 2_500_000: clock cycles per step at tempo 1.
- TICK_FAST, default 1_250_000: clock cycles per step at tempo 2.
- CNT_W, default 23: tick counter width; must hold TICK_SLOW-1.

Ports:
- clk, input, 1: system clock; one clock domain.
- n_rst, input, 1: asynchronous, active-low reset.
- piano_keys, input, 15: live key levels, one bit per key.
- seq_power, input, 1: sequencer on/off button level.
- tempo_select, input, 1: tempo cycle button level.
- seq_play, input, 1: edit/play toggle button level.
- note_out, output, 15: key vector to the oscillator; all-zero means silence.
- mode_out, output, 2: 00 OFF, 01 EDIT, 10 PLAY; 11 is never driven.
- beat_led, output, 8: one-hot current step pointer; zero in OFF.
- seq_led_on, output, 1: high in EDIT or PLAY.

## Operation
- All inputs are already synchronized. The block keeps a one-cycle registered copy of each input. A rise is input=1 with previous=0. A rise on piano_keys means the OR of per-bit rises.
- Storage:
  - step memory: 8 × 15 bits;
  - ptr: 3 bits;
  - tempo index: 2 bits, values 0..2;
  - tick counter: CNT_W bits.
- States: OFF, EDIT, PLAY.
  - OFF: note_out = piano_keys (registered). seq_power rise → EDIT; all 8 steps cleared to 0, ptr=0.
  - EDIT: note_out = piano_keys (registered). Key rise → step[ptr] ← the full current piano_keys vector, so chords are allowed; then ptr ← ptr+1 mod 8, wrapping 7→0 and overwriting. seq_play rise → PLAY with ptr=0 and counter=0. seq_power rise → OFF.
  - PLAY: note_out = step[ptr]. The counter increments each cycle. When counter = TICK[tempo]-1: counter ← 0, ptr ← ptr+1 mod 8. seq_play rise → EDIT with ptr=0; memory is kept. seq_power rise → OFF. Key rises are ignored.
- Tempo:
  - tempo_select rise → tempo ← (tempo+1) mod 3 in any state.
  - In PLAY, a tempo change also zeroes the counter; ptr is unchanged.
- Priority for rises in the same cycle: seq_power > seq_play > key capture. The lower-priority event is dropped. Tempo is handled independently and always applied.
- Memory is written only in EDIT, and is cleared only on reset or OFF→EDIT.

## Timing
- Reset values:
  - state OFF, ptr 0, tempo 0, counter 0, all steps 0;
  - all input history registers 0;
  - note_out 0, mode_out 00, beat_led 00000000, seq_led_on 0.
- All outputs are registered or decoded from registers only.
- Latency: an input first sampled high at edge N (previous low) updates state at edge N. Outputs reflect the change after edge N, one cycle after the input rises.
- Live pass-through latency is 1 clock.
- PLAY step period is exactly TICK[tempo] cycles. The first advance occurs TICK cycles after PLAY entry.
- A button held high produces exactly one rise.
- Asserting n_rst mid-PLAY or mid-EDIT immediately forces all reset values; stored steps are lost.

## Configuration
- SASS_SEQ_GATE_EN defined:
  - In PLAY, note_out is forced to 0 while counter ≥ TICK[tempo] − TICK[tempo]/4 (integer division). This gives a staccato gap in each step.
  - In OFF and EDIT, note_out is not gated.
- SASS_SEQ_GATE_EN undefined:
  - step[ptr] is held for the entire step.
  - The gating comparator is absent.

## Test plan
Bench overrides TICK_SLOW=8, TICK_MED=4, TICK_FAST=2, CNT_W=4.
- Reset then idle → note_out=0, mode_out=00, beat_led=0, seq_led_on=0. Drive piano_keys=15'h0005 → note_out=15'h0005 one cycle later.
- seq_power pulse, then key rises of 15'h0001, 15'h0002, …, 15'h0080 → mode_out=01. beat_led walks 01→02→…→80→01, wrapping after 8 captures.
- From the above state, seq_play pulse → mode_out=10, note_out=15'h0001. It advances to 15'h0002 after 8 cycles. After 64 cycles it is back at step 0.
- In PLAY, tempo_select pulse → counter zeroes and steps advance every 4 cycles. Two more pulses → tempo returns to 0 with 8-cycle steps.
- seq_power and seq_play rise in the same cycle while in EDIT → state OFF, beat_led=0. A key rise in the same cycle as seq_play in EDIT → no memory write, state PLAY.
- With SASS_SEQ_GATE_EN at tempo 0, step 0=15'h0010 → note_out=15'h0010 for 6 cycles, then 0 for 2 cycles. Assert n_rst mid-step → all reset values.
